prog_loader: RTL and testbench

- Byte-stream program loader for the instruction memory.
- Sits directly downstream of the reset controller: its active-low `reset` input is driven by the controller's `program_reset`, so it runs only while the system is in program mode.
- Receives a framed byte stream from the UART receiver (one-cycle valid pulses) and assembles little-endian 32-bit words.
- Writes those words to sequential instruction-memory word addresses and reports done/error, word count and an XOR checksum for host/LED readback.

---
 rtl/prog_loader.sv | 108 ++++++++++
 tb/tb_prog_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words from a framed UART
// stream and writes them to sequential instruction-memory addresses.
module prog_loader #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wd,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW:0]   word_count,
   output logic [31:0]   checksum
);

   typedef enum logic [1:0] {LEN, DATA, DONE, ERR} state_t;

   localparam logic [31:0] CAPACITY = 32'(1) << AW;

   state_t      state, state_next;
   logic [1:0]  byte_idx;
   logic [23:0] low_bytes;
   logic [AW:0] target;
   logic [AW:0] next_count;
   logic [31:0] full_word;
   logic        accepting;
   logic        word_end;

   // The 4th byte is combined straight from rx_data so the write can issue next cycle.
   assign full_word  = {rx_data, low_bytes};
   assign accepting  = rx_valid && ((state == LEN) || (state == DATA));
   assign word_end   = accepting && (byte_idx == 2'd3);
   assign next_count = word_count + (AW+1)'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= LEN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (word_end) begin
         case (state)
            LEN: begin
               if (full_word == 32'd0) begin
                  state_next = DONE;
               end else if (full_word > CAPACITY) begin
                  state_next = ERR;
               end else begin
                  state_next = DATA;
               end
            end
            DATA: begin
               if (next_count == target) begin
                  state_next = DONE;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         byte_idx   <= 2'd0;
         low_bytes  <= 24'd0;
         target     <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wd     <= 32'd0;
         word_count <= '0;
         checksum   <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (accepting) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    low_bytes[7:0]   <= rx_data;
               2'd1:    low_bytes[15:8]  <= rx_data;
               2'd2:    low_bytes[23:16] <= rx_data;
               default: low_bytes        <= low_bytes;
            endcase
         end
         if (word_end && (state == LEN)) begin
            target <= full_word[AW:0];
         end
         if (word_end && (state == DATA)) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[AW-1:0];
            mem_wd     <= full_word;
            word_count <= next_count;
            checksum   <= checksum ^ full_word;
         end
      end
   end

   assign busy  = (state == DATA);
   assign done  = (state == DONE);
   assign error = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a byte-counting frame model predicts every
// output each cycle, and literal checks pin the directed scenarios.
module tb_prog_loader;

   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wd;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   word_count;
   logic [31:0]   checksum;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   prog_loader #(.AW(AW)) dut (
      .clk(clk),
      .reset(reset),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wd(mem_wd),
      .busy(busy),
      .done(done),
      .error(error),
      .word_count(word_count),
      .checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: counts frame bytes, so the length and words fall out of byte positions.
   logic          exp_we, exp_busy, exp_done, exp_err;
   logic [AW-1:0] exp_addr;
   logic [31:0]   exp_wd, exp_sum, m_len, m_word;
   logic [AW:0]   exp_count;
   int            m_bytes;

   always @(posedge clk) begin
      int pos;
      cyc = cyc + 1;
      exp_we = 1'b0;
      if (!reset) begin
         m_bytes = 0; m_len = 0; m_word = 0;
         exp_busy = 0; exp_done = 0; exp_err = 0;
         exp_addr = 0; exp_wd = 0; exp_count = 0; exp_sum = 0;
      end else if (rx_valid && !exp_done && !exp_err) begin
         if (m_bytes < 4) begin
            m_len[8*m_bytes +: 8] = rx_data;
            m_bytes = m_bytes + 1;
            if (m_bytes == 4) begin
               if (m_len == 0) exp_done = 1'b1;
               else if (m_len > (32'd1 << AW)) exp_err = 1'b1;
               else exp_busy = 1'b1;
            end
         end else begin
            pos = (m_bytes - 4) % 4;
            m_word[8*pos +: 8] = rx_data;
            m_bytes = m_bytes + 1;
            if (pos == 3) begin
               exp_we = 1'b1;
               exp_addr = exp_count[AW-1:0];
               exp_wd = m_word;
               exp_count = exp_count + 1'b1;
               exp_sum = exp_sum ^ m_word;
               m_word = 0;
               if (32'(exp_count) == m_len) begin
                  exp_done = 1'b1;
                  exp_busy = 1'b0;
               end
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] req);
      vectors = vectors + 1;
      if (act !== req) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (cyc > 0)
         check_output("outputs{we,addr,wd,busy,done,err,count,sum}",
            96'({mem_we, mem_addr, mem_wd, busy, done, error, word_count, checksum}),
            96'({exp_we, exp_addr, exp_wd, exp_busy, exp_done, exp_err, exp_count, exp_sum}));
   end

   // Event logs used by the literal checks.
   int          wr_cyc[$];
   logic [31:0] wr_data[$];
   int          wr_addr[$];
   int          byte_cyc[$];

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_data.push_back(mem_wd);
         wr_addr.push_back(int'(mem_addr));
      end
      if (rx_valid && reset) byte_cyc.push_back(cyc);
   end

   task automatic clear_logs();
      wr_cyc.delete(); wr_data.delete(); wr_addr.delete(); byte_cyc.delete();
   endtask

   task automatic idle(input int n);
      @(posedge clk); #2;
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input logic [7:0] b, input int gap);
      @(posedge clk); #2;
      rx_valid = 1'b1;
      rx_data = b;
      if (gap > 0) begin
         @(posedge clk); #2;
         rx_valid = 1'b0;
         rx_data = 8'($urandom);
         repeat (gap - 1) @(posedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) apply_stimulus(w[8*i +: 8], gap);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #2;
      reset = 1'b0;
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #2;
      reset = 1'b1;
      clear_logs();
   endtask

   initial begin
      reset = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;

      // Reset held with rx_valid pulsing.
      repeat (2) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         rx_valid = 1'b1;
         rx_data = 8'($urandom);
      end
      @(posedge clk); #2;
      rx_valid = 1'b0;
      reset = 1'b1;
      clear_logs();
      @(negedge clk);
      check_output("reset_busy_done", 96'({busy, done}), 96'(0));
      check_output("reset_count", 96'(word_count), 96'(0));

      // Basic load with a gap between bytes, then post-done bytes are ignored.
      send_word(32'd2, 1);
      send_word(32'h00000013, 1);
      send_word(32'h00100093, 1);
      idle(4);
      check_output("basic_nwrites", 96'(wr_cyc.size()), 96'(2));
      if (wr_cyc.size() == 2 && byte_cyc.size() >= 8) begin
         check_output("basic_w0", 96'({wr_addr[0], wr_data[0]}), 96'({32'd0, 32'h00000013}));
         check_output("basic_w0_latency", 96'(wr_cyc[0] - byte_cyc[7]), 96'(1));
         check_output("basic_w1", 96'({wr_addr[1], wr_data[1]}), 96'({32'd1, 32'h00100093}));
      end
      check_output("basic_final", 96'({done, busy, word_count, checksum}),
                   96'({1'b1, 1'b0, 11'd2, 32'h00100080}));
      for (int i = 0; i < 8; i++) apply_stimulus(8'($urandom), $urandom_range(0, 1));
      idle(3);
      check_output("ignore_nwrites", 96'(wr_cyc.size()), 96'(2));
      check_output("ignore_final", 96'({done, word_count, checksum}),
                   96'({1'b1, 11'd2, 32'h00100080}));

      // Back-to-back bytes.
      do_reset(1);
      send_word(32'd2, 0);
      send_word(32'h00000013, 0);
      send_word(32'h00100093, 0);
      idle(4);
      check_output("b2b_nwrites", 96'(wr_cyc.size()), 96'(2));
      if (wr_cyc.size() == 2) begin
         check_output("b2b_spacing", 96'(wr_cyc[1] - wr_cyc[0]), 96'(4));
         check_output("b2b_data", 96'({wr_data[0], wr_data[1]}), 96'({32'h00000013, 32'h00100093}));
      end

      // N = 0.
      do_reset(1);
      send_word(32'd0, 1);
      @(negedge clk);
      check_output("n0_done", 96'({done, busy, error}), 96'({1'b1, 1'b0, 1'b0}));
      idle(2);
      check_output("n0_nwrites", 96'(wr_cyc.size()), 96'(0));

      // N = 0x401 overflows capacity; following bytes must be ignored.
      do_reset(1);
      send_word(32'h00000401, 0);
      idle(1);
      check_output("over_error", 96'({error, busy, done}), 96'({1'b1, 1'b0, 1'b0}));
      send_word(32'hCAFEF00D, 0);
      send_word(32'h12345678, 1);
      idle(2);
      check_output("over_nwrites", 96'(wr_cyc.size()), 96'(0));

      // N = 0x400 fills the whole memory.
      do_reset(1);
      send_word(32'h00000400, 1);
      @(negedge clk);
      check_output("full_busy", 96'(busy), 96'(1));
      for (int i = 0; i < 1024; i++) send_word($urandom, $urandom_range(0, 1));
      idle(3);
      check_output("full_nwrites", 96'(wr_cyc.size()), 96'(1024));
      if (wr_cyc.size() > 0)
         check_output("full_last_addr", 96'(wr_addr[wr_addr.size()-1]), 96'(32'h3FF));
      check_output("full_final", 96'({done, word_count}), 96'({1'b1, 11'h400}));

      // Reset mid-word discards the partial frame.
      do_reset(1);
      send_word(32'd1, 1);
      apply_stimulus(8'hAA, 1);
      apply_stimulus(8'h55, 1);
      do_reset(1);
      send_word(32'd1, 1);
      send_word(32'hDEADBEEF, 1);
      idle(2);
      check_output("midreset_nwrites", 96'(wr_cyc.size()), 96'(1));
      if (wr_cyc.size() == 1)
         check_output("midreset_w0", 96'({wr_addr[0], wr_data[0]}), 96'({32'd0, 32'hDEADBEEF}));
      check_output("midreset_final", 96'({done, word_count, checksum}),
                   96'({1'b1, 11'd1, 32'hDEADBEEF}));

      // Random frames, some cut short by reset; the per-cycle model does the checking.
      for (int f = 0; f < 8; f++) begin
         int n;
         int cut;
         do_reset($urandom_range(1, 2));
         n = $urandom_range(1, 6);
         cut = (f % 3 == 2) ? $urandom_range(1, 4 + 4*n - 1) : -1;
         for (int b = 0; b < 4 + 4*n; b++) begin
            if (b == cut) do_reset(1);
            if (b < 4) apply_stimulus(8'(n >> (8*b)), $urandom_range(0, 2));
            else apply_stimulus(8'($urandom), $urandom_range(0, 2));
         end
         idle(3);
      end

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
